// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Grants are same-cycle; read responses return one cycle after the granted access.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_a,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] din_a,
   output logic                  gnt_a,
   output logic                  rvalid_a,
   input  logic                  req_b,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] din_b,
   output logic                  gnt_b,
   output logic                  rvalid_b,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_t;

   prio_t                 prio_r;
   prio_t                 prio_nxt_s;
   logic                  rd_pend_a_r;
   logic                  rd_pend_b_r;
   logic                  rd_pend_a_nxt_s;
   logic                  rd_pend_b_nxt_s;
   logic [ADDR_WIDTH-1:0] last_addr_r;
   logic [ADDR_WIDTH-1:0] last_addr_nxt_s;
   logic                  gnt_a_s;
   logic                  gnt_b_s;

   // Arbitration: lone requester wins, ties go to the preferred side; no grant in reset.
   always_comb begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
      if (rst_n) begin
         case ({req_a, req_b})
            2'b10: gnt_a_s = 1'b1;
            2'b01: gnt_b_s = 1'b1;
            2'b11: begin
               if (prio_r == PRIO_B) begin
                  gnt_b_s = 1'b1;
               end else begin
                  gnt_a_s = 1'b1;
               end
            end
            default: begin
               gnt_a_s = 1'b0;
               gnt_b_s = 1'b0;
            end
         endcase
      end else begin
         gnt_a_s = 1'b0;
         gnt_b_s = 1'b0;
      end
   end

   // RAM port mux; an idle port holds the last granted address with writes disabled.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = last_addr_r;
      ram_din  = {DATA_WIDTH{1'b0}};
      case ({gnt_a_s, gnt_b_s})
         2'b10: begin
            ram_we   = we_a;
            ram_addr = addr_a;
            ram_din  = din_a;
         end
         2'b01: begin
            ram_we   = we_b;
            ram_addr = addr_b;
            ram_din  = din_b;
         end
         default: begin
            ram_we   = 1'b0;
            ram_addr = last_addr_r;
            ram_din  = {DATA_WIDTH{1'b0}};
         end
      endcase
   end

   // Next-state: priority flips to the loser, read flags track a granted read for one cycle.
   always_comb begin
      prio_nxt_s      = prio_r;
      last_addr_nxt_s = last_addr_r;
      rd_pend_a_nxt_s = gnt_a_s & ~we_a;
      rd_pend_b_nxt_s = gnt_b_s & ~we_b;
      if (gnt_a_s) begin
         prio_nxt_s      = PRIO_B;
         last_addr_nxt_s = addr_a;
      end else if (gnt_b_s) begin
         prio_nxt_s      = PRIO_A;
         last_addr_nxt_s = addr_b;
      end else begin
         prio_nxt_s      = prio_r;
         last_addr_nxt_s = last_addr_r;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_r      <= PRIO_A;
         rd_pend_a_r <= 1'b0;
         rd_pend_b_r <= 1'b0;
         last_addr_r <= {ADDR_WIDTH{1'b0}};
      end else begin
         prio_r      <= prio_nxt_s;
         rd_pend_a_r <= rd_pend_a_nxt_s;
         rd_pend_b_r <= rd_pend_b_nxt_s;
         last_addr_r <= last_addr_nxt_s;
      end
   end

   assign gnt_a    = gnt_a_s;
   assign gnt_b    = gnt_b_s;
   assign rvalid_a = rd_pend_a_r;
   assign rvalid_b = rd_pend_b_r;
   assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: table of per-cycle vectors plus hand-written reset sequences,
// with a behavioural RAM and a read-response scoreboard.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, we_a, req_b, we_b;
   logic [7:0] addr_a, din_a, addr_b, din_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0] rdata, ram_addr, ram_din, ram_dout;
   logic       ram_we;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
      .gnt_a(gnt_a), .rvalid_a(rvalid_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
      .gnt_b(gnt_b), .rvalid_b(rvalid_b),
      .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   // Behavioural single-port RAM: write at edge, registered read address
   logic [7:0] mem [256];
   logic [7:0] raddr_q = 8'h00;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      raddr_q <= ram_addr;
   end
   assign ram_dout = mem[raddr_q];

   typedef struct {
      logic       ra, wa;
      logic [7:0] aa, da;
      logic       rb, wb;
      logic [7:0] ab, db;
      logic       eg_a, eg_b;
      logic [7:0] e_addr;
   } vec_t;

   typedef struct {
      logic       side;   // 0 = A, 1 = B
      logic [7:0] data;
   } rsp_t;

   vec_t       vecs[$];
   rsp_t       sb[$];
   logic [7:0] ref_mem [256];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic vec_t mk(logic ra, logic wa, logic [7:0] aa, logic [7:0] da,
                               logic rb, logic wb, logic [7:0] ab, logic [7:0] db,
                               logic eg_a, logic eg_b, logic [7:0] e_addr);
      vec_t v;
      v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
      v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
      v.eg_a = eg_a; v.eg_b = eg_b; v.e_addr = e_addr;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      logic       e_we;
      logic [7:0] e_din;
      logic       e_rva, e_rvb;
      rsp_t       r;
      @(posedge clk);
      #1;
      req_a = v.ra; we_a = v.wa; addr_a = v.aa; din_a = v.da;
      req_b = v.rb; we_b = v.wb; addr_b = v.ab; din_b = v.db;
      #4;
      e_we  = v.eg_a ? v.wa : (v.eg_b ? v.wb : 1'b0);
      e_din = v.eg_a ? v.da : (v.eg_b ? v.db : 8'h00);
      chk($sformatf("gnt_a[%0d]", idx), 32'(gnt_a), 32'(v.eg_a));
      chk($sformatf("gnt_b[%0d]", idx), 32'(gnt_b), 32'(v.eg_b));
      chk($sformatf("ram_we[%0d]", idx), 32'(ram_we), 32'(e_we));
      chk($sformatf("ram_addr[%0d]", idx), 32'(ram_addr), 32'(v.e_addr));
      chk($sformatf("ram_din[%0d]", idx), 32'(ram_din), 32'(e_din));
      e_rva = (sb.size() > 0) && (sb[0].side == 1'b0);
      e_rvb = (sb.size() > 0) && (sb[0].side == 1'b1);
      chk($sformatf("rvalid_a[%0d]", idx), 32'(rvalid_a), 32'(e_rva));
      chk($sformatf("rvalid_b[%0d]", idx), 32'(rvalid_b), 32'(e_rvb));
      if (sb.size() > 0) begin
         r = sb.pop_front();
         chk($sformatf("rdata[%0d]", idx), 32'(rdata), 32'(r.data));
      end
      if (v.eg_a && !v.wa) sb.push_back('{side: 1'b0, data: ref_mem[v.aa]});
      if (v.eg_b && !v.wb) sb.push_back('{side: 1'b1, data: ref_mem[v.ab]});
      if (v.eg_a && v.wa) ref_mem[v.aa] = v.da;
      if (v.eg_b && v.wb) ref_mem[v.ab] = v.db;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst_n = 1'b0;
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h44; din_a = 8'hA5;
      req_b = 1'b1; we_b = 1'b1; addr_b = 8'h55; din_b = 8'h5A;

      // Outputs held quiet during reset even with both sides requesting writes
      #7;
      chk("rst_gnt_a", 32'(gnt_a), 32'd0);
      chk("rst_gnt_b", 32'(gnt_b), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_din", 32'(ram_din), 32'd0);
      chk("rst_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #4;
      chk("first_gnt_a", 32'(gnt_a), 32'd1);
      chk("first_gnt_b", 32'(gnt_b), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt_a", 32'(gnt_a), 32'd0);
      chk("midrst_gnt_b", 32'(gnt_b), 32'd0);
      chk("midrst_ram_we", 32'(ram_we), 32'd0);
      req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single requester, B write to line up prio, contention, cross RAW, idle, tie with prio=B
      vecs.push_back(mk(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10));
      vecs.push_back(mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h11, 8'h77, 1'b0, 1'b1, 8'h11));
      for (int i = 0; i < 6; i++) begin
         vecs.push_back(mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h11, 8'h00,
                           (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? 8'h10 : 8'h11));
      end
      vecs.push_back(mk(1'b1, 1'b1, 8'h20, 8'hC3, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h20));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, 8'h20));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h20));
      vecs.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h99, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF));
      for (int i = 0; i < 10; i++) begin
         vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF));
      end
      vecs.push_back(mk(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF));
      vecs.push_back(mk(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20));
      vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h20));

      foreach (vecs[i]) run_vec(vecs[i], i);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      // Reset while a B read response is outstanding
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 8'h11;
      #4;
      chk("rr_gnt_b", 32'(gnt_b), 32'd1);
      @(posedge clk); #1;
      req_b = 1'b0;
      chk("rr_rvalid_b_pend", 32'(rvalid_b), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rr_rvalid_b_drop", 32'(rvalid_b), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h30; din_a = 8'h3C;
      #4;
      chk("rr_gnt_a", 32'(gnt_a), 32'd1);
      chk("rr_rvalid_b_after", 32'(rvalid_b), 32'd0);

      // A grant leaves prio=B; reset must restore A preference
      @(posedge clk); #1;
      req_a = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10;
      req_b = 1'b1; we_b = 1'b0; addr_b = 8'h11;
      #4;
      chk("prio_rst_gnt_a", 32'(gnt_a), 32'd1);
      chk("prio_rst_gnt_b", 32'(gnt_b), 32'd0);
      @(posedge clk); #1;
      req_a = 1'b0; req_b = 1'b0;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one single-port synchronous RAM (write on clock edge, registered read address, read data valid the cycle after the access) between two requesters, A and B. Each cycle it grants at most one access using round-robin priority. It drives the RAM port and routes the read-response strobe back to the requester that issued the read. It sits directly in front of the RAM instance and is the only master of the RAM port.

Parameters:
ADDR_WIDTH, 8, RAM address width
DATA_WIDTH, 8, RAM data width

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
req_a  input  1  requester A access request; held until granted
we_a  input  1  A: 1 = write, 0 = read; valid while req_a=1
addr_a  input  ADDR_WIDTH  A access address
din_a  input  DATA_WIDTH  A write data
gnt_a  output  1  A access accepted this cycle (combinational)
rvalid_a  output  1  read data for A valid on rdata this cycle
req_b  input  1  requester B access request; held until granted
we_b  input  1  B: 1 = write, 0 = read
addr_b  input  ADDR_WIDTH  B access address
din_b  input  DATA_WIDTH  B write data
gnt_b  output  1  B access accepted this cycle (combinational)
rvalid_b  output  1  read data for B valid on rdata this cycle
rdata  output  DATA_WIDTH  shared read-data return; equals ram_dout
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_din  output  DATA_WIDTH  RAM write data
ram_dout  input  DATA_WIDTH  RAM read data (from registered address)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low: rst_n=0 immediately forces all state registers to their reset values.
- State:
  - prio: 0 = A preferred, 1 = B preferred; reset value 0.
  - rd_pend_a, rd_pend_b: read-response pipeline flags; reset value 0.
- Arbitration (combinational, same cycle):
  - Only req_a: grant A. Only req_b: grant B. Both: grant the side named by prio. Neither: no grant.
  - At most one of gnt_a and gnt_b is high in any cycle.
  - gnt_x is forced to 0 while rst_n=0.
- prio update: on a clock edge with a grant, prio is set to the non-granted side (A granted -> prio=1; B granted -> prio=0). prio is unchanged on idle cycles.
- RAM port mux:
  - Grant to X: ram_addr=addr_x, ram_din=din_x, ram_we=we_x.
  - No grant: ram_we=0, ram_addr=last granted address (held register, reset 0), ram_din=0.
  - ram_we is never high without a grant.
- Read latency is exactly 1 cycle:
  - A granted read (gnt_x=1, we_x=0) sets rd_pend_x=1 at the next edge. Every other cycle clears it at the next edge.
  - rvalid_a=rd_pend_a and rvalid_b=rd_pend_b.
  - rdata=ram_dout unconditionally.
  - Back-to-back reads by the same requester give rvalid high on consecutive cycles.
  - rvalid_a and rvalid_b are never both high.
- Writes produce no response; the write completes at the grant edge.
- Read-after-write from the other requester: the write is granted in cycle N, the read in cycle N+1, and rdata in cycle N+2 returns the new value.
- Requester rules:
  - After raising req_x, the requester holds req_x, we_x, addr_x and din_x stable until it sees gnt_x=1.
  - It may keep req_x high to issue the next access in the following cycle.
- Reset mid-operation: an outstanding read response is dropped (rvalid forced 0) and prio returns to 0. Requesters must reissue.
- Outputs during/after reset: gnt_a=gnt_b=rvalid_a=rvalid_b=0, ram_we=0, ram_addr=0, ram_din=0. rdata follows ram_dout.
- Fairness: under continuous dual requests, grants alternate A,B,A,B... Neither requester waits more than 1 cycle.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with req_a=req_b=1 -> gnt_a, gnt_b, ram_we go 0 immediately; after release with both requesting, first grant goes to A (prio=0).
- Single requester: A writes 0x5A to addr 0x10, then reads 0x10 -> gnt_a in both cycles; rvalid_a=1 with rdata=0x5A in the cycle after the read grant; rvalid_b stays 0.
- Contention: req_a and req_b held high for 6 cycles, all reads -> grant order A,B,A,B,A,B; rvalid_a/rvalid_b alternate with a 1-cycle lag; never both high.
- Cross read-after-write: A writes 0xC3 to 0x20 while B requests a read of 0x20 in the same cycle with prio=0 -> A granted in cycle N, B in N+1; rdata=0xC3 with rvalid_b=1 in N+2.
- Reset during read: B granted a read, then rst_n pulsed low before the next edge completes -> rvalid_b stays 0; prio=0 after release.
- Idle: no requests for 10 cycles after a write to 0xFF -> ram_we=0 throughout, ram_addr holds 0xFF, prio unchanged.
